// File: rtl/lowampa_trig_pkg.sv
// lowampa_trig_pkg: shared state encoding and default sizes for the low-amplitude trigger gate.
package lowampa_trig_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, PENDING, HOLDOFF} state_t;

   localparam int COLLECT_LEN_DEF  = 4;
   localparam int HOLDOFF_BITS_DEF = 16;
   localparam int DROP_BITS_DEF    = 16;

endpackage

// File: rtl/lowampa_trigger_gate_sat_counter.sv
// sat_counter: saturating up-counter; a synchronous clear wins over a same-cycle increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // clear first, otherwise count up and stick at all-ones
   always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   // count register
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;

   assign cnt_o = cnt_q;

endmodule

// File: rtl/lowampa_trigger_gate.sv
// lowampa_trigger_gate: masks beam triggers, merges a coincidence window into one record,
// hands it off over valid/ready and then holds off. Define LOWAMPA_TRIG_TIMESTAMP_EN to add trig_time_o.
module lowampa_trigger_gate
   import lowampa_trig_pkg::*;
#(
   parameter int NBEAMS       = 54,
   parameter int COLLECT_LEN  = COLLECT_LEN_DEF,
   parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF,
   parameter int DROP_BITS    = DROP_BITS_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NBEAMS-1:0]       trig_i,
   input  logic [NBEAMS-1:0]       beam_mask_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   output logic                    trig_valid_o,
   input  logic                    trig_ready_i,
   output logic [NBEAMS-1:0]       trig_beams_o,
   output logic                    busy_o,
`ifdef LOWAMPA_TRIG_TIMESTAMP_EN
   output logic [31:0]             trig_time_o,
`endif
   output logic [DROP_BITS-1:0]    dropped_o,
   input  logic                    dropped_clr_i
);

   localparam logic [3:0] WIN_INIT = 4'(COLLECT_LEN - 1);

   state_t                  state_q, state_d;
   logic [3:0]              win_q, win_d;
   logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
   logic [NBEAMS-1:0]       beams_q, beams_d;
   logic [NBEAMS-1:0]       masked;
   logic                    hit;
`ifdef LOWAMPA_TRIG_TIMESTAMP_EN
   logic [31:0]             cyc_q, time_q, time_d;
`endif

   assign masked = trig_i & beam_mask_i;
   assign hit    = |masked;

   // window collection, handshake and holdoff sequencing
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      hold_d  = hold_q;
      beams_d = beams_q;
`ifdef LOWAMPA_TRIG_TIMESTAMP_EN
      time_d  = time_q;
`endif
      unique case (state_q)
         IDLE:
            if (hit) begin
               beams_d = masked;
               win_d   = WIN_INIT;
               state_d = (COLLECT_LEN == 1) ? PENDING : COLLECT;
`ifdef LOWAMPA_TRIG_TIMESTAMP_EN
               time_d  = cyc_q;
`endif
            end
         COLLECT: begin
            beams_d = beams_q | masked;
            win_d   = win_q - 1'b1;
            if (win_q == 4'd1) state_d = PENDING;
         end
         PENDING:
            if (trig_ready_i) begin
               hold_d  = holdoff_i - 1'b1;
               state_d = (holdoff_i == '0) ? IDLE : HOLDOFF;
            end
         HOLDOFF: begin
            hold_d = hold_q - 1'b1;
            if (hold_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and record registers; reset discards any pending record
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         win_q   <= '0;
         hold_q  <= '0;
         beams_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         hold_q  <= hold_d;
         beams_q <= beams_d;
      end

`ifdef LOWAMPA_TRIG_TIMESTAMP_EN
   // free-running cycle counter and captured first-hit time
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         cyc_q  <= '0;
         time_q <= '0;
      end else begin
         cyc_q  <= cyc_q + 1'b1;
         time_q <= time_d;
      end

   assign trig_time_o = time_q;
`endif

   sat_counter #(.W(DROP_BITS)) u_drop (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (dropped_clr_i),
      .inc_i (hit && (state_q == PENDING || state_q == HOLDOFF)),
      .cnt_o (dropped_o)
   );

   assign trig_valid_o = (state_q == PENDING);
   assign busy_o       = (state_q != IDLE);
   assign trig_beams_o = beams_q;

endmodule
